// File: rtl/coin_dispenser.sv
// coin_dispenser: pays an owed amount as a series of coins sent to the hopper.
// Each coin is offered with a valid/ack handshake. Large coins are chosen first,
// and the block never pays more than is owed. It also tracks the small and large
// coin inventory, including refills.
module coin_dispenser #(
  parameter int AMT_W      = 4,
  parameter int CNT_W      = 6,
  parameter int INIT_SMALL = 20,
  parameter int INIT_LARGE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic [1:0]       coin,
  output logic             coin_valid,
  input  logic             coin_ack,
  input  logic             refill_small,
  input  logic             refill_large,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] small_cnt,
  output logic [CNT_W-1:0] large_cnt
);

  localparam logic [1:0] COIN_NONE  = 2'b00;
  localparam logic [1:0] COIN_SMALL = 2'b01;
  localparam logic [1:0] COIN_LARGE = 2'b10;

  typedef enum logic [1:0] {IDLE, PICK, ISSUE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       coin_next;
  logic             coin_valid_next;
  logic             done_next;
  logic             short_next;
  logic             short_flag_reg, short_flag_next;
  logic [AMT_W-1:0] remaining_next;
  logic             take_small, take_large;
  logic [CNT_W-1:0] small_cnt_next, large_cnt_next;

  // A refill and a dispense of the same coin in one cycle cancel out.
  // A refill on its own saturates at the counter maximum.
  function automatic logic [CNT_W-1:0] inv_update(input logic [CNT_W-1:0] cnt,
                                                  input logic add,
                                                  input logic sub);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (add && !sub) begin
      if (cnt != {CNT_W{1'b1}}) res = cnt + CNT_W'(1);
    end else if (sub && !add) begin
      res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  assign req_ready = (state_reg == IDLE);

  // Next-state, registered-output and coin-selection logic.
  always_comb begin
    state_next      = state_reg;
    coin_next       = coin;
    coin_valid_next = coin_valid;
    done_next       = 1'b0;
    short_next      = 1'b0;
    short_flag_next = short_flag_reg;
    remaining_next  = remaining;
    take_small      = 1'b0;
    take_large      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          remaining_next  = req_amount;
          short_flag_next = 1'b0;
          state_next      = (req_amount == '0) ? DONE : PICK;
        end
      end
      PICK: begin
        // Decisions use the registered counts, so a refill arriving now only
        // affects the next pick.
        if (remaining >= AMT_W'(2) && large_cnt != '0) begin
          coin_next       = COIN_LARGE;
          coin_valid_next = 1'b1;
          state_next      = ISSUE;
        end else if (remaining >= AMT_W'(1) && small_cnt != '0) begin
          coin_next       = COIN_SMALL;
          coin_valid_next = 1'b1;
          state_next      = ISSUE;
        end else begin
          short_flag_next = 1'b1;
          state_next      = DONE;
        end
      end
      ISSUE: begin
        if (coin_ack) begin
          coin_valid_next = 1'b0;
          coin_next       = COIN_NONE;
          if (coin == COIN_LARGE) begin
            take_large     = 1'b1;
            remaining_next = remaining - AMT_W'(2);
          end else begin
            take_small     = 1'b1;
            remaining_next = remaining - AMT_W'(1);
          end
          state_next = (remaining_next == '0) ? DONE : PICK;
        end
      end
      DONE: begin
        done_next  = 1'b1;
        short_next = short_flag_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    small_cnt_next = inv_update(small_cnt, refill_small, take_small);
    large_cnt_next = inv_update(large_cnt, refill_large, take_large);
  end

  // State and registered outputs. Reset aborts any request and reloads the
  // inventory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      coin           <= COIN_NONE;
      coin_valid     <= 1'b0;
      done           <= 1'b0;
      short          <= 1'b0;
      short_flag_reg <= 1'b0;
      remaining      <= '0;
      small_cnt      <= CNT_W'(INIT_SMALL);
      large_cnt      <= CNT_W'(INIT_LARGE);
    end else begin
      state_reg      <= state_next;
      coin           <= coin_next;
      coin_valid     <= coin_valid_next;
      done           <= done_next;
      short          <= short_next;
      short_flag_reg <= short_flag_next;
      remaining      <= remaining_next;
      small_cnt      <= small_cnt_next;
      large_cnt      <= large_cnt_next;
    end
  end

endmodule

// File: tb/tb_coin_dispenser.sv
// Testbench for coin_dispenser.
// The reference model works from the payment rules directly: it tracks the
// amount owed and the inventory as plain integers.
module tb_coin_dispenser;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_amount;
  logic       req_ready;
  logic [1:0] coin;
  logic       coin_valid;
  logic       coin_ack;
  logic       refill_small;
  logic       refill_large;
  logic       done;
  logic       short;
  logic [3:0] remaining;
  logic [5:0] small_cnt;
  logic [5:0] large_cnt;

  int checks   = 0;
  int failures = 0;
  int m_small  = 20;
  int m_large  = 10;

  coin_dispenser #(.AMT_W(4), .CNT_W(6), .INIT_SMALL(20), .INIT_LARGE(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_amount   (req_amount),
    .req_ready    (req_ready),
    .coin         (coin),
    .coin_valid   (coin_valid),
    .coin_ack     (coin_ack),
    .refill_small (refill_small),
    .refill_large (refill_large),
    .done         (done),
    .short        (short),
    .remaining    (remaining),
    .small_cnt    (small_cnt),
    .large_cnt    (large_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge. Outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clip(input int v);
    return (v > 63) ? 63 : v;
  endfunction

  task automatic chk_counts(input string tag);
    chk({tag, "_small"}, 32'(small_cnt), m_small);
    chk({tag, "_large"}, 32'(large_cnt), m_large);
  endtask

  task automatic refill(input bit s, input bit l);
    refill_small = s;
    refill_large = l;
    tick();
    refill_small = 1'b0;
    refill_large = 1'b0;
    m_small = clip(m_small + int'(s));
    m_large = clip(m_large + int'(l));
    chk_counts("refill");
  endtask

  // Runs one request from start to finish and checks every cycle against the
  // model. hold < 0 means a random ack delay. rs/rl pulse a refill in the ack
  // cycle of each coin.
  task automatic run_req(input int amount, input int hold, input bit rs, input bit rl);
    int         rem;
    int         k;
    bit         is_short;
    logic [1:0] exp_coin;
    rem      = amount;
    is_short = 1'b0;
    chk("ready_idle", 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_amount = amount[3:0];
    tick();
    req_valid  = 1'b0;
    req_amount = 4'($urandom);
    chk("ready_busy", 32'(req_ready), 0);
    while (rem > 0) begin
      if (rem >= 2 && m_large > 0) exp_coin = 2'b10;
      else if (m_small > 0)        exp_coin = 2'b01;
      else begin
        is_short = 1'b1;
        break;
      end
      // The ack line is noise here: no coin is offered yet.
      coin_ack = 1'($urandom_range(0, 1));
      chk("valid_pick", 32'(coin_valid), 0);
      tick();
      coin_ack = 1'b0;
      chk("coin_valid", 32'(coin_valid), 1);
      chk("coin", 32'(coin), 32'(exp_coin));
      k = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
      repeat (k) begin
        tick();
        chk("hold_valid", 32'(coin_valid), 1);
        chk("hold_coin", 32'(coin), 32'(exp_coin));
        chk("hold_large", 32'(large_cnt), m_large);
      end
      coin_ack     = 1'b1;
      refill_small = rs;
      refill_large = rl;
      tick();
      coin_ack     = 1'b0;
      refill_small = 1'b0;
      refill_large = 1'b0;
      if (exp_coin == 2'b10) begin
        rem     = rem - 2;
        m_large = clip(m_large + int'(rl) - 1);
        m_small = clip(m_small + int'(rs));
      end else begin
        rem     = rem - 1;
        m_small = clip(m_small + int'(rs) - 1);
        m_large = clip(m_large + int'(rl));
      end
      chk("ack_valid", 32'(coin_valid), 0);
      chk("ack_coin", 32'(coin), 0);
      chk("ack_rem", 32'(remaining), rem);
      chk_counts("ack");
    end
    coin_ack = 1'b0;
    if (is_short) begin
      tick();
      chk("done_early", 32'(done), 0);
    end
    tick();
    chk("done", 32'(done), 1);
    chk("short", 32'(short), int'(is_short));
    chk("done_rem", 32'(remaining), rem);
    chk("done_valid", 32'(coin_valid), 0);
    chk("ready_done", 32'(req_ready), 1);
    chk_counts("done");
    tick();
    chk("done_pulse", 32'(done), 0);
    $display("req amount=%0d short=%0d rem=%0d small=%0d large=%0d",
             amount, is_short, rem, m_small, m_large);
  endtask

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_amount   = '0;
    coin_ack     = 1'b0;
    refill_small = 1'b0;
    refill_large = 1'b0;
    #1 rst = 1'b1;
    #1;
    // Reset state applies before any clock edge.
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_valid", 32'(coin_valid), 0);
    chk("rst_coin", 32'(coin), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_short", 32'(short), 0);
    chk("rst_rem", 32'(remaining), 0);
    chk_counts("rst");
    tick();
    tick();
    rst = 1'b0;

    // Amount 5 with ack answered immediately: pays 10, 10, 01.
    run_req(5, 0, 1'b0, 1'b0);
    chk("t2_small", 32'(small_cnt), 19);
    chk("t2_large", 32'(large_cnt), 8);

    // Amount 2 with ack held low for 3 cycles.
    run_req(2, 3, 1'b0, 1'b0);
    chk("t3_large", 32'(large_cnt), 7);

    // Large refill in the same cycle as a large-coin ack: net no change.
    run_req(2, 1, 1'b0, 1'b1);
    chk("t6_large", 32'(large_cnt), 7);

    // Reset during ISSUE clears the coin at once and reloads the inventory.
    req_valid  = 1'b1;
    req_amount = 4'd5;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t1_issue", 32'(coin_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_valid", 32'(coin_valid), 0);
    chk("t1_coin", 32'(coin), 0);
    chk("t1_small", 32'(small_cnt), 20);
    chk("t1_large", 32'(large_cnt), 10);
    m_small = 20;
    m_large = 10;
    tick();
    rst = 1'b0;
    tick();
    chk("t1_ready", 32'(req_ready), 1);
    chk("t1_done", 32'(done), 0);

    // Use up all large coins, then pay 3 in small coins only.
    while (m_large > 0) run_req(2, -1, 1'b0, 1'b0);
    run_req(3, -1, 1'b0, 1'b0);

    // Use up all small coins, add one large coin, then request 3.
    // Expected: one large coin, then short with 1 unpaid.
    while (m_small > 0) run_req((m_small > 15) ? 15 : m_small, 0, 1'b0, 1'b0);
    refill(1'b0, 1'b1);
    run_req(3, -1, 1'b0, 1'b0);
    chk("t5_rem", 32'(remaining), 1);
    run_req(0, 0, 1'b0, 1'b0);

    // Small-coin inventory saturates at 63.
    repeat (70) refill(1'b1, 1'b0);
    chk("t6_sat", 32'(small_cnt), 63);

    // Random requests, refills and ack delays.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) refill(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_req(int'($urandom_range(0, 15)), -1,
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
